// File: rtl/mul_unit.sv
// Iterative multiply / multiply-accumulate unit (MUL, MLA, UMULL, SMULL) with a start/busy/done handshake.
// Signed products use sign-magnitude: operands are made positive on accept and the product is negated at the end.
module mul_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] Acc,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int unsigned NSTEP = WIDTH / STEPS;
    localparam int unsigned CNT_W = $clog2(NSTEP + 1);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned SW    = WIDTH + STEPS;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MLA   = 2'b01;
    localparam logic [1:0] OP_UMULL = 2'b10;
    localparam logic [1:0] OP_SMULL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [1:0]         flags_q, flags_d;

    logic               is_smull;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [SW-1:0]      step_sum;
    logic [PW-1:0]      prod_step;
    logic [PW-1:0]      prod_fin;
    logic [WIDTH-1:0]   res_lo, res_hi;
    logic               res_n, res_z;

    // Operand conditioning at accept time.
    always_comb begin
        is_smull = (Op == OP_SMULL);
        abs_a    = (is_smull && SrcA[WIDTH-1]) ? WIDTH'(-SrcA) : SrcA;
        abs_b    = (is_smull && SrcB[WIDTH-1]) ? WIDTH'(-SrcB) : SrcB;
    end

    // One shift-add step: upper half accumulates, multiplier bits shift out the bottom.
    always_comb begin
        step_sum  = SW'(prod_q[PW-1:WIDTH]) + SW'(mcand_q) * SW'(prod_q[STEPS-1:0]);
        prod_step = {step_sum, prod_q[WIDTH-1:STEPS]};
        prod_fin  = neg_q ? PW'(-prod_step) : prod_step;
    end

    // Final result selection, accumulate and flags for the last RUN edge.
    always_comb begin
        res_lo = prod_fin[WIDTH-1:0];
        res_hi = '0;
        case (op_q)
            OP_MUL:           res_lo = prod_fin[WIDTH-1:0];
            OP_MLA:           res_lo = prod_fin[WIDTH-1:0] + acc_q;
            OP_UMULL, OP_SMULL: begin
                res_lo = prod_fin[WIDTH-1:0];
                res_hi = prod_fin[PW-1:WIDTH];
            end
        endcase
        res_n = op_q[1] ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
        res_z = op_q[1] ? ({res_hi, res_lo} == '0) : (res_lo == '0);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start) begin
                    state_d = S_RUN;
                    op_d    = Op;
                    acc_d   = Acc;
                    mcand_d = abs_a;
                    prod_d  = {WIDTH'(0), abs_b};
                    neg_d   = is_smull && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    cnt_d   = CNT_W'(NSTEP);
                end
            end
            S_RUN: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    lo_d    = res_lo;
                    hi_d    = res_hi;
                    flags_d = {res_n, res_z};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
        end
    end

    assign Busy     = (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);
    assign ResultLo = lo_q;
    assign ResultHi = hi_q;
    assign MulFlags = flags_q;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: one instance retiring 1 bit/cycle, one retiring 4 bits/cycle.
module tb_mul_unit;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  fl;
        int unsigned at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    logic        rst1, st1, busy1, done1;
    logic [1:0]  op1, fl1;
    logic [31:0] a1, b1, acc1, lo1, hi1;
    logic        rst4, st4, busy4, done4;
    logic [1:0]  op4, fl4;
    logic [31:0] a4, b4, acc4, lo4, hi4;

    exp_t q1[$];
    exp_t q4[$];

    mul_unit #(.WIDTH(32), .STEPS(1)) dut1 (
        .clk(clk), .reset(rst1), .Start(st1), .Op(op1), .SrcA(a1), .SrcB(b1), .Acc(acc1),
        .Busy(busy1), .Done(done1), .ResultLo(lo1), .ResultHi(hi1), .MulFlags(fl1)
    );

    mul_unit #(.WIDTH(32), .STEPS(4)) dut4 (
        .clk(clk), .reset(rst4), .Start(st4), .Op(op4), .SrcA(a4), .SrcB(b4), .Acc(acc4),
        .Busy(busy4), .Done(done4), .ResultLo(lo4), .ResultHi(hi4), .MulFlags(fl4)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitors: every Done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL d1_spurious_done: got Done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = q1.pop_front();
                chk("d1_lo", 64'(lo1), 64'(e.lo));
                chk("d1_hi", 64'(hi1), 64'(e.hi));
                chk("d1_flags", 64'(fl1), 64'(e.fl));
                chk("d1_done_cycle", 64'(cyc), 64'(e.at));
                chk("d1_busy_in_done", 64'(busy1), 64'(0));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL d4_spurious_done: got Done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = q4.pop_front();
                chk("d4_lo", 64'(lo4), 64'(e.lo));
                chk("d4_hi", 64'(hi4), 64'(e.hi));
                chk("d4_flags", 64'(fl4), 64'(e.fl));
                chk("d4_done_cycle", 64'(cyc), 64'(e.at));
                chk("d4_busy_in_done", 64'(busy4), 64'(0));
            end
        end
    end

    task automatic drive(input int d, input logic s, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (d == 1) begin
            st1 = s; op1 = op; a1 = a; b1 = b; acc1 = c;
        end else begin
            st4 = s; op4 = op; a4 = a; b4 = b; acc4 = c;
        end
    endtask

    // Called at a negedge; returns one negedge later (first Busy cycle).
    task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [31:0] elo,
                         input logic [31:0] ehi, input logic [1:0] efl, input bit track);
        exp_t e;
        drive(d, 1'b1, op, a, b, c);
        if (track) begin
            e.lo = elo; e.hi = ehi; e.fl = efl;
            e.at = cyc + ((d == 1) ? 33 : 9);
            if (d == 1) q1.push_back(e); else q4.push_back(e);
        end
        @(negedge clk);
        drive(d, 1'b0, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 32'h5A5A5A5A);
    endtask

    task automatic drain(input int d);
        int k = 0;
        while (((d == 1) ? q1.size() : q4.size()) != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (((d == 1) ? q1.size() : q4.size()) != 0) begin
            n_vec++; n_miss++;
            $display("FAIL d%0d_timeout: got no Done within %0d cycles, expected one", d, k);
            if (d == 1) q1.delete(); else q4.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst1 = 1'b1; rst4 = 1'b1;
        drive(1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        drive(4, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'({busy1, busy4}), 64'(0));
        chk("rst_done", 64'({done1, done4}), 64'(0));
        chk("rst_res1", {lo1, hi1}, 64'(0));
        chk("rst_res4", {lo4, hi4}, 64'(0));
        chk("rst_flags", 64'({fl1, fl4}), 64'(0));
        rst1 = 1'b0; rst4 = 1'b0;
        @(negedge clk);

        // MUL 7x6 with Busy window checks.
        issue(1, 2'b00, 32'd7, 32'd6, 32'd0, 32'h0000002A, 32'h0, 2'b00, 1'b1);
        chk("mul_busy_c1", 64'(busy1), 64'(1));
        repeat (31) @(negedge clk);
        chk("mul_busy_c32", 64'(busy1), 64'(1));
        chk("mul_nodone_c32", 64'(done1), 64'(0));
        @(negedge clk);
        chk("mul_busy_c33", 64'(busy1), 64'(0));
        drain(1);

        issue(1, 2'b01, 32'hFFFFFFFF, 32'd2, 32'd5, 32'h00000003, 32'h0, 2'b00, 1'b1);
        drain(1);
        issue(1, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'hFFFFFFFE, 2'b10, 1'b1);
        drain(1);
        issue(1, 2'b11, 32'hFFFFFFFD, 32'd5, 32'h0, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10, 1'b1);
        drain(1);
        issue(1, 2'b11, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 2'b00, 1'b1);
        drain(1);

        // MUL 0x0x1234 with an ignored Start in cycle 5; previous result must hold.
        issue(1, 2'b00, 32'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 2'b01, 1'b1);
        repeat (4) @(negedge clk);
        chk("hold_hi_run", 64'(hi1), 64'(32'h40000000));
        drive(1, 1'b1, 2'b10, 32'd9, 32'd9, 32'd0);
        @(negedge clk);
        drive(1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        drain(1);

        // Nonzero result, then a run killed by reset in cycle 10.
        issue(1, 2'b00, 32'd7, 32'd6, 32'd0, 32'h0000002A, 32'h0, 2'b00, 1'b1);
        drain(1);
        issue(1, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0);
        repeat (9) @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("midrst_busy", 64'(busy1), 64'(0));
        chk("midrst_done", 64'(done1), 64'(0));
        chk("midrst_res", {lo1, hi1}, 64'(0));
        chk("midrst_flags", 64'(fl1), 64'(0));
        repeat (40) @(negedge clk);
        chk("midrst_idle", 64'(busy1), 64'(0));

        // STEPS=4: Start held high through the run, back-to-back MUL 3x3 on the Done cycle.
        drive(4, 1'b1, 2'b10, 32'h12345678, 32'h9ABCDEF0, 32'h0);
        e.lo = 32'h242D2080; e.hi = 32'h0B00EA4E; e.fl = 2'b00; e.at = cyc + 9;
        q4.push_back(e);
        repeat (8) @(negedge clk);
        chk("d4_busy_c8", 64'(busy4), 64'(1));
        @(negedge clk);
        drive(4, 1'b1, 2'b00, 32'd3, 32'd3, 32'h0);
        e.lo = 32'd9; e.hi = 32'h0; e.fl = 2'b00; e.at = cyc + 9;
        q4.push_back(e);
        @(negedge clk);
        drive(4, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        chk("b2b_busy", 64'(busy4), 64'(1));
        chk("b2b_hold", {hi4, lo4}, 64'h0B00EA4E_242D2080);
        drain(4);

        issue(4, 2'b11, 32'hFFFFFFFD, 32'd5, 32'h0, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10, 1'b1);
        drain(4);
        issue(4, 2'b11, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 2'b00, 1'b1);
        drain(4);
        issue(4, 2'b01, 32'h00010000, 32'h00010000, 32'h00000000, 32'h0, 32'h0, 2'b01, 1'b1);
        drain(4);
        issue(4, 2'b11, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000001, 32'hFFFFFFFF, 2'b10, 1'b1);
        drain(4);
        issue(4, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'h0, 2'b00, 1'b1);
        drain(4);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
